// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared types and helpers for the bit-serial adder.
//   state_t : controller states (IDLE, RUN, DONE)
//   cnt_w() : width of the bit counter for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must be able to hold every value from 0 to width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell
// One-bit full adder built from two half-adder stages and an OR.
// Ports:
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out (majority of a, b, cin)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  // First half adder combines the operand bits, the second folds in the
  // carry; at most one of the two stages can generate a carry, so an OR
  // merges them into the majority function.
  always_comb begin
    s1   = a ^ b;
    c1   = a & b;
    s    = s1 ^ cin;
    c2   = s1 & cin;
    cout = c1 | c2;
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial ripple adder: accepts A, B, Cin over a valid/ready handshake,
// adds one bit pair per clock LSB first through a single full-adder cell,
// and returns Sum, Cout and signed Overflow over a second handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   A, B, Cin           : operands and carry-in
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   Sum, Cout, Overflow : result, carry out of MSB, two's-complement overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_c;
  logic             msb_cycle;

  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign msb_cycle = (cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; the handshake outputs depend only on the state so
  // there is no combinational path from inputs to in_ready/out_valid.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (msb_cycle) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand load on accept, one bit per RUN cycle, and capture of
  // the carry flags on the MSB cycle. The overflow flag uses the carry into
  // the MSB, which is the carry register before this cycle's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= A;
            b_sh   <= B;
            carry  <= Cin;
            cnt    <= '0;
            sum_sh <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (msb_cycle) begin
            cout_q <= fa_c;
            ovf_q  <= carry ^ fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign Sum      = sum_sh;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Directed self-checking bench for serial_adder with WIDTH = 8.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;

  int checks;
  int failures;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Overflow  (Overflow)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one operand set for a single accepting edge, then wait out the
  // RUN cycles, checking latency and the result.
  task automatic applyStimulus(input string tag, input logic [7:0] a,
                               input logic [7:0] b, input logic cin,
                               input logic [7:0] expSum, input logic expCout,
                               input logic expOvf);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    A        = a;
    B        = b;
    Cin      = cin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput({tag, "_busy"}, 32'(in_ready), 32'd0);
    for (int i = 1; i <= WIDTH; i++) begin
      @(posedge clk);
      #1;
      if (i == WIDTH - 1) checkOutput({tag, "_early"}, 32'(out_valid), 32'd0);
    end
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_sum"}, 32'(Sum), 32'(expSum));
    checkOutput({tag, "_cout"}, 32'(Cout), 32'(expCout));
    checkOutput({tag, "_ovf"}, 32'(Overflow), 32'(expOvf));
  endtask

  // Hand the result off and confirm the return to IDLE.
  task automatic drainResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sum", 32'(Sum), 32'd0);
    checkOutput("rst_cout", 32'(Cout), 32'd0);
    checkOutput("rst_ovf", 32'(Overflow), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("v0f01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    drainResult("v0f01");
    applyStimulus("vff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    drainResult("vff01");
    applyStimulus("v7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    drainResult("v7f01");
    applyStimulus("vffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    drainResult("vffff");
    applyStimulus("vcin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    drainResult("vcin");
    applyStimulus("v80ff", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
    drainResult("v80ff");

    // Backpressure: hold the result for five cycles with a stray request.
    applyStimulus("bp", 8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        A        = 8'h01;
        B        = 8'h01;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_hold_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_hold_sum", 32'(Sum), 32'h7F);
      checkOutput("bp_hold_cout", 32'(Cout), 32'd0);
      checkOutput("bp_hold_ovf", 32'(Overflow), 32'd0);
    end
    drainResult("bp");
    @(posedge clk);
    #1;
    checkOutput("bp_no_queue", 32'(in_ready), 32'd1);

    // Reset four cycles into an operation.
    A        = 8'h55;
    B        = 8'h55;
    Cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mid_sum_partial", 32'(Sum), 32'hA0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_sum", 32'(Sum), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("v8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    drainResult("v8080");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
